// File: rtl/router_pkt_tx.sv
// Router 1x3 packet source: buffers a payload, then streams header, payload and
// parity into the router input port while honouring busy back-pressure.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       soft_reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       ready,
    output logic       load_req,
    output logic       tx_done,
    output logic       len_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] wptr_q, wptr_d;
    logic [5:0] rptr_q, rptr_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       lerr_q, lerr_d;
    logic [7:0] buf_q [64];

    logic       buf_we_s;
    logic       len_bad_s;
    logic       fill_last_s;
    logic [7:0] hdr_s;
    logic [7:0] start_hdr_s;
    logic [7:0] rd_byte_s;

    assign len_bad_s   = (payload_len == 6'd0) || ({1'b0, payload_len} > MAX_LEN_C);
    assign fill_last_s = (({1'b0, wptr_q} + 7'd1) == {1'b0, len_q});
    assign hdr_s       = {len_q, addr_q};
    assign start_hdr_s = {payload_len, dest_addr};
    assign rd_byte_s   = buf_q[rptr_q];

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        parity_d = parity_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        lerr_d   = 1'b0;
        buf_we_s = 1'b0;
        if (soft_reset) begin
            state_d  = S_IDLE;
            wptr_d   = 6'd0;
            rptr_d   = 6'd0;
            parity_d = 8'd0;
            dout_d   = 8'd0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dout_d  = 8'd0;
                    valid_d = 1'b0;
                    if (start) begin
                        if (len_bad_s) begin
                            lerr_d = 1'b1;
                        end else begin
                            addr_d   = dest_addr;
                            len_d    = payload_len;
                            wptr_d   = 6'd0;
                            parity_d = start_hdr_s;
                            state_d  = S_FILL;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FILL: begin
                    if (wr_en) begin
                        buf_we_s = 1'b1;
                        parity_d = parity_q ^ wr_data;
                        wptr_d   = wptr_q + 6'd1;
                        if (fill_last_s) begin
                            state_d = S_HEADER;
                            dout_d  = hdr_s;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        dout_d  = buf_q[0];
                        rptr_d  = 6'd1;
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_HEADER;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        // rptr already points past the byte being accepted
                        if (rptr_q == len_q) begin
                            dout_d  = parity_q;
                            valid_d = 1'b0;
                            state_d = S_PARITY;
                        end else begin
                            dout_d = rd_byte_s;
                            rptr_d = rptr_q + 6'd1;
                        end
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        dout_d  = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    dout_d  = 8'd0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            wptr_q   <= 6'd0;
            rptr_q   <= 6'd0;
            parity_q <= 8'd0;
            dout_q   <= 8'd0;
            valid_q  <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            parity_q <= parity_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            lerr_q   <= lerr_d;
        end
    end

    // Payload buffer write port
    always_ff @(posedge clock) begin
        if (buf_we_s) begin
            buf_q[wptr_q] <= wr_data;
        end
    end

    assign data_out  = dout_q;
    assign pkt_valid = valid_q;
    assign len_err   = lerr_q;
    assign ready     = (state_q == S_IDLE);
    assign load_req  = (state_q == S_FILL);
    assign tx_done   = (state_q == S_DONE);

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the Router 1x3 input port: the source side of the router packet protocol. It accepts a destination address, a payload length, and a burst of payload bytes into an internal buffer. It then emits one contiguous packet into the router's `data_in`/`pkt_valid` inputs: header, payload, then the parity byte. It honours the router's `busy` back-pressure and is used as the traffic source in system-level benches and on the chip's host-side ingress.

## Interface
- `MAX_LEN`, default 63: largest legal payload length (≤63); the buffer holds 64 bytes.
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous abort to IDLE; priority over every other input except `resetn`.
- `start`  in  1  request a packet; sampled only in IDLE.
- `dest_addr`  in  2  destination port; captured on an accepted `start`.
- `payload_len`  in  6  payload byte count; captured on an accepted `start`.
- `wr_en`  in  1  payload byte strobe; honoured only in FILL.
- `wr_data`  in  8  payload byte.
- `busy`  in  1  router back-pressure; while high, the current byte is held.
- `data_out`  out  8  byte to router `data_in`; registered.
- `pkt_valid`  out  1  to router; high for the header and payload bytes, low for the parity byte; registered.
- `ready`  out  1  high in IDLE.
- `load_req`  out  1  high in FILL.
- `tx_done`  out  1  one-cycle pulse after the parity byte is accepted.
- `len_err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- **Header byte:** `{payload_len[5:0], dest_addr[1:0]}`.
- **Parity:** XOR of the header and all payload bytes, accumulated during FILL.
- **Byte transfer:** a byte is "accepted" at a rising edge where the state is HEADER, PAYLOAD or PARITY and `busy`=0.
- **IDLE:** `pkt_valid`=0, `data_out`=0.
  - `start` with `payload_len`=0 or >`MAX_LEN`: pulse `len_err`, stay in IDLE.
  - Otherwise: capture the address and length, set `wptr`=0, set parity = header, go to FILL.
- **FILL:** each edge with `wr_en` writes `buf[wptr]`, XORs the byte into parity, and increments `wptr`. The write that makes `wptr`==len moves the state to HEADER and loads `data_out`=header, `pkt_valid`=1.
- **HEADER:** holds the header while `busy`=1. On accept, `data_out`=`buf[0]`, `rptr`=1, go to PAYLOAD.
- **PAYLOAD:** `pkt_valid`=1 and the current byte is held while `busy`=1. On accept:
  - if `rptr`==len: `data_out`=parity, `pkt_valid`=0, go to PARITY;
  - else: `data_out`=`buf[rptr]`, increment `rptr`.
- **PARITY:** parity is held while `busy`=1. On accept, `data_out`=0, go to DONE.
- **DONE:** `tx_done`=1 for one cycle, then IDLE. `start` in DONE is ignored.
- **Ignored inputs:** `start` outside IDLE; `wr_en` outside FILL.
- **soft_reset:** state, pointers and parity go to IDLE/0 at the next edge; `pkt_valid`=0, `data_out`=0. No `tx_done` or `len_err`. It beats a simultaneous `start`.
- **Buffer read:** the implementation may use an asynchronous register-file read or a prefetch, but output timing must match the above exactly.

## Timing
- **Reset values:** `data_out`=0x00, `pkt_valid`=0, `tx_done`=0, `len_err`=0, `load_req`=0, `ready`=1. Reset takes effect immediately, including mid-packet.
- **Start:** `start` at edge T puts the block in FILL (`load_req`=1) from T+1.
- **Fill to header:** the header is driven in the cycle after the edge that writes the last payload byte.
- **Packet duration with `busy`=0:**
  - header: 1 cycle;
  - payload: len consecutive cycles;
  - parity: 1 cycle;
  - `tx_done`: 1 cycle;
  - `ready` returns on the next cycle.
  - `pkt_valid` is high for exactly len+1 cycles, with no gaps.
- **Back-pressure:** each cycle of `busy`=1 in HEADER, PAYLOAD or PARITY stretches that byte by exactly one cycle. Bytes are never dropped or duplicated.
- **Fill pacing:** gaps in `wr_en` during FILL only delay the header; the transmitted packet is never gapped.

## Test plan
- **Async reset mid-packet:** assert `resetn`=0 mid-PAYLOAD → immediately `pkt_valid`=0, `data_out`=0x00, `ready`=1; after release, the next packet is correct.
- **Nominal packet:** len=14, addr=01, payloads 0x01..0x0E, `busy`=0 → header 0x39, then 0x01..0x0E, with `pkt_valid`=1 for 15 consecutive cycles. Then parity 0x36 with `pkt_valid`=0, then one `tx_done` cycle.
- **Back-pressure:** len=2, addr=10, payloads 0xAA, 0x55; `busy`=1 for 3 cycles during HEADER and 2 cycles during PARITY → 0x0A held 4 cycles, 0xAA and 0x55 one cycle each, 0xF5 held 3 cycles.
- **Length errors:** `start` with len=0 → `len_err` pulse, `ready` stays 1, `pkt_valid` never rises. Repeat with `MAX_LEN`=8 and len=9 → same result.
- **Abort during FILL:** len=5, `soft_reset` after 3 writes → IDLE next cycle. A following len=1 packet with addr=00 and payload 0x7F gives header 0x04, payload 0x7F, parity 0x7B.
- **Ignored inputs:** `start` held high through DONE is ignored; it is accepted on the first IDLE cycle. `wr_en` pulses in IDLE and HEADER do not change the buffer or the parity.
